// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : Shared constants for the ALU sequencer: opcodes, instruction
//            field positions, FSM state encoding and an opcode classifier.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

   // Opcodes held in instruction bits [15:14]
   localparam logic [1:0] OP_ADDI = 2'b00;
   localparam logic [1:0] OP_MOV  = 2'b01;
   localparam logic [1:0] OP_HALT = 2'b10;
   localparam logic [1:0] OP_ILL  = 2'b11;

   // Instruction field bit positions
   localparam int OP_HI  = 15;
   localparam int OP_LO  = 14;
   localparam int RD_HI  = 13;
   localparam int RD_LO  = 11;
   localparam int RS_HI  = 10;
   localparam int RS_LO  = 8;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_HALTED = 3'd5;

   // Only addi and mov write the register file and count as retired
   function automatic logic op_writes(input logic [1:0] op);
      return (op == OP_ADDI) || (op == OP_MOV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_pc.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pc
// Brief    : Program counter: loads RST_PC on reset, increments with natural
//            wrap at 2^PC_W-1 -> 0 when inc_i is high, otherwise holds.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_pc #(
   parameter int              PC_W   = 8,
   parameter logic [PC_W-1:0] RST_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inc_i,
   output logic [PC_W-1:0] pc_o
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;

   // Next PC: fixed-width add, so the all-ones value rolls over to zero
   always_comb begin
      pc_d = pc_q;
      if (inc_i) begin
         pc_d = pc_q + PC_W'(1);
      end
   end

   // PC register with synchronous reset load
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= RST_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Brief    : Multi-cycle fetch/decode/exec/writeback sequencer for the 8-bit
//            ALU. Optional feature macro: SEQ_HALT_EN (op 10 = HALT).
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int              PC_W   = 8,
   parameter logic [PC_W-1:0] RST_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic            stop_i,
   output logic            imem_req_o,
   output logic [PC_W-1:0] imem_addr_o,
   input  logic [15:0]     imem_rdata_i,
   input  logic            imem_valid_i,
   output logic [2:0]      rf_raddr_o,
   output logic            alu_ctrl_o,
   output logic [7:0]      alu_imm_o,
   output logic            rf_we_o,
   output logic [2:0]      rf_waddr_o,
   output logic            busy_o,
   output logic            halted_o,
   output logic            illegal_o,
   output logic [15:0]     retired_o
);

`ifdef SEQ_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic [2:0]      state_q, state_d;
   logic [15:0]     instr_q;
   logic            illegal_q;
   logic [15:0]     retired_q;
   logic [PC_W-1:0] pc;
   logic            pc_inc;

   logic [1:0] op;
   logic       op_wr;
   logic       op_halt;

   assign op      = instr_q[OP_HI:OP_LO];
   assign op_wr   = op_writes(op);
   assign op_halt = HALT_EN && (op == OP_HALT);

   // A halting instruction parks the PC on itself; resuming steps past it
   assign pc_inc = ((state_q == ST_WB) && !op_halt) ||
                   ((state_q == ST_HALTED) && start_i);

   alu_seq_pc #(
      .PC_W   (PC_W),
      .RST_PC (RST_PC)
   ) u_pc (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (pc_inc),
      .pc_o  (pc)
   );

   // Next-state logic; stop is only honoured at the end of writeback
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_i)      state_d = ST_FETCH;
         ST_FETCH:  if (imem_valid_i) state_d = ST_DECODE;
         ST_DECODE:                   state_d = ST_EXEC;
         ST_EXEC:                     state_d = ST_WB;
         ST_WB: begin
            if (op_halt)      state_d = ST_HALTED;
            else if (stop_i)  state_d = ST_IDLE;
            else              state_d = ST_FETCH;
         end
         ST_HALTED: if (start_i)      state_d = ST_FETCH;
         default:                     state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Instruction latch, captured only on the accepted fetch beat
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_q <= '0;
      end else if ((state_q == ST_FETCH) && imem_valid_i) begin
         instr_q <= imem_rdata_i;
      end
   end

   // Sticky illegal flag, cleared only by reset or a start from IDLE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         illegal_q <= 1'b0;
      end else if ((state_q == ST_IDLE) && start_i) begin
         illegal_q <= 1'b0;
      end else if ((state_q == ST_WB) && !op_wr && !op_halt) begin
         illegal_q <= 1'b1;
      end
   end

   // Saturating retired-instruction counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retired_q <= '0;
      end else if ((state_q == ST_WB) && op_wr && (retired_q != 16'hFFFF)) begin
         retired_q <= retired_q + 16'd1;
      end
   end

   // Decoded fields come straight from the latch, so they stay stable from
   // DECODE through WB without extra registers
   assign imem_req_o  = (state_q == ST_FETCH);
   assign imem_addr_o = pc;
   assign rf_raddr_o  = instr_q[RS_HI:RS_LO];
   assign alu_ctrl_o  = op[0];
   assign alu_imm_o   = instr_q[IMM_HI:IMM_LO];
   assign rf_we_o     = (state_q == ST_WB) && op_wr;
   assign rf_waddr_o  = rf_we_o ? instr_q[RD_HI:RD_LO] : 3'd0;
   assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_HALTED);
   assign illegal_o   = illegal_q;
   assign retired_o   = retired_q;

`ifdef SEQ_HALT_EN
   assign halted_o = (state_q == ST_HALTED);
`else
   assign halted_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Brief    : Directed self-checking bench for alu_seq_ctrl with a simple
//            imem responder of programmable wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, start, stop;
   logic        imem_req, imem_valid;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic [2:0]  rf_raddr, rf_waddr;
   logic        alu_ctrl, rf_we, busy, halted, illegal;
   logic [7:0]  alu_imm;
   logic [15:0] retired;

   int checks = 0;
   int fails  = 0;

   logic [15:0] mem [256];
   int          lat = 0;
   int          wait_cnt = 0;
   int          cyc = 0;
   int          fetch_cnt = 0;
   int          req_cycles = 0;
   int          addr_bad = 0;
   int          stop_after = 0;
   bit          auto_stop = 0;
   logic        prev_req = 0, prev_valid = 0;
   logic [7:0]  prev_addr = 0;

   typedef struct {int c; logic [2:0] wa; logic [2:0] ra; logic ctl; logic [7:0] imm;} we_t;
   we_t        we_q[$];
   logic [7:0] fa_q[$];

   always #5 clk = ~clk;

   alu_seq_ctrl #(.PC_W(8), .RST_PC(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
      .imem_valid_i(imem_valid), .rf_raddr_o(rf_raddr), .alu_ctrl_o(alu_ctrl),
      .alu_imm_o(alu_imm), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .busy_o(busy),
      .halted_o(halted), .illegal_o(illegal), .retired_o(retired)
   );

   // Instruction memory: data valid once the request has waited lat cycles
   assign imem_valid = imem_req && (wait_cnt >= lat);
   assign imem_rdata = mem[imem_addr];

   always @(posedge clk) begin
      if (imem_req && !imem_valid) wait_cnt <= wait_cnt + 1;
      else                         wait_cnt <= 0;
   end

   // Activity recorder and automatic stop generation
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (imem_req) begin
         req_cycles = req_cycles + 1;
         if (prev_req && !prev_valid && (imem_addr != prev_addr)) addr_bad = addr_bad + 1;
      end
      if (imem_req && imem_valid) begin
         fa_q.push_back(imem_addr);
         fetch_cnt = fetch_cnt + 1;
      end
      if (rf_we) we_q.push_back('{cyc, rf_waddr, rf_raddr, alu_ctrl, alu_imm});
      prev_req = imem_req; prev_valid = imem_valid; prev_addr = imem_addr;
      if (auto_stop) stop = (fetch_cnt >= stop_after);
   end

   function automatic logic [15:0] enc(input logic [1:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [7:0] imm);
      return {op, rd, rs, imm};
   endfunction

   // Pulse start and wait (bounded) for the sequencer to go idle or halted
   task automatic run_prog(input int n_stop, input int latency);
      we_q.delete(); fa_q.delete();
      fetch_cnt = 0; req_cycles = 0; addr_bad = 0;
      lat = latency; stop_after = n_stop; auto_stop = 1;
      stop = (0 >= n_stop);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      checks++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL run_timeout: busy=%0b required 0", busy);
      end
      auto_stop = 0; stop = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %0b required 0", imem_req); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b required 0", busy); end
      checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rst_we: got %0b required 0", rf_we); end
      checks++; if (imem_addr !== 8'h00) begin fails++; $display("FAIL rst_addr: got %0h required 0", imem_addr); end
      checks++; if (retired !== 16'h0) begin fails++; $display("FAIL rst_retired: got %0h required 0", retired); end
      checks++; if (illegal !== 1'b0) begin fails++; $display("FAIL rst_illegal: got %0b required 0", illegal); end
      checks++; if (halted !== 1'b0) begin fails++; $display("FAIL rst_halted: got %0b required 0", halted); end
      checks++; if ({rf_raddr, alu_ctrl, alu_imm} !== 12'h0) begin fails++; $display("FAIL rst_decode: got %0h required 0", {rf_raddr, alu_ctrl, alu_imm}); end
   endtask

   task automatic test_two_instr();
      run_prog(2, 0);
      checks++; if (we_q.size() !== 2) begin fails++; $display("FAIL two_we_count: got %0d required 2", we_q.size()); end
      if (we_q.size() == 2) begin
         checks++; if (we_q[1].c - we_q[0].c !== 4) begin fails++; $display("FAIL two_we_spacing: got %0d required 4", we_q[1].c - we_q[0].c); end
         checks++; if (we_q[0].wa !== 3'd1) begin fails++; $display("FAIL two_waddr0: got %0d required 1", we_q[0].wa); end
         checks++; if (we_q[1].wa !== 3'd2) begin fails++; $display("FAIL two_waddr1: got %0d required 2", we_q[1].wa); end
         checks++; if ({we_q[0].ra, we_q[0].ctl, we_q[0].imm} !== {3'd0, 1'b0, 8'd5}) begin
            fails++; $display("FAIL two_dec0: got ra=%0d ctl=%0b imm=%0h required ra=0 ctl=0 imm=5", we_q[0].ra, we_q[0].ctl, we_q[0].imm); end
         checks++; if ({we_q[1].ra, we_q[1].ctl} !== {3'd1, 1'b1}) begin
            fails++; $display("FAIL two_dec1: got ra=%0d ctl=%0b required ra=1 ctl=1", we_q[1].ra, we_q[1].ctl); end
      end
      checks++; if (retired !== 16'd2) begin fails++; $display("FAIL two_retired: got %0d required 2", retired); end
      checks++; if (imem_addr !== 8'd2) begin fails++; $display("FAIL two_pc: got %0d required 2", imem_addr); end
   endtask

   task automatic test_wait_states();
      mem[2] = enc(2'b00, 3'd3, 3'd2, 8'h11);
      run_prog(1, 3);
      checks++; if (req_cycles !== 4) begin fails++; $display("FAIL ws_req_cycles: got %0d required 4", req_cycles); end
      checks++; if (addr_bad !== 0) begin fails++; $display("FAIL ws_addr_stable: got %0d changes required 0", addr_bad); end
      checks++; if (fetch_cnt !== 1) begin fails++; $display("FAIL ws_latches: got %0d required 1", fetch_cnt); end
      checks++; if (we_q.size() !== 1) begin fails++; $display("FAIL ws_we_count: got %0d required 1", we_q.size()); end
      else begin checks++; if (we_q[0].wa !== 3'd3) begin fails++; $display("FAIL ws_waddr: got %0d required 3", we_q[0].wa); end end
      checks++; if (retired !== 16'd3) begin fails++; $display("FAIL ws_retired: got %0d required 3", retired); end
   endtask

   task automatic test_pc_wrap();
      run_prog(252, 0);
      checks++; if (imem_addr !== 8'hFF) begin fails++; $display("FAIL wrap_pre_pc: got %0h required ff", imem_addr); end
      run_prog(1, 0);
      checks++; if (imem_addr !== 8'h00) begin fails++; $display("FAIL wrap_pc: got %0h required 0", imem_addr); end
      checks++; if (retired !== 16'd256) begin fails++; $display("FAIL wrap_retired: got %0d required 256", retired); end
      run_prog(1, 0);
      checks++; if (fa_q.size() !== 1 || fa_q[0] !== 8'h00) begin fails++; $display("FAIL wrap_next_fetch: got %0h required 0", (fa_q.size() > 0) ? fa_q[0] : 8'hXX); end
   endtask

   task automatic test_reset_mid();
      lat = 10; stop = 1'b0;
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL mid_in_fetch: req=%0b required 1", imem_req); end
      we_q.delete();
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL mid_req: got %0b required 0", imem_req); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %0b required 0", busy); end
      checks++; if (imem_addr !== 8'h00) begin fails++; $display("FAIL mid_pc: got %0h required 0", imem_addr); end
      checks++; if (retired !== 16'd0) begin fails++; $display("FAIL mid_retired: got %0d required 0", retired); end
      rst_n = 1'b1; lat = 0;
      repeat (2) @(negedge clk);
      checks++; if (we_q.size() !== 0 || busy !== 1'b0) begin fails++; $display("FAIL mid_quiet: we=%0d busy=%0b required 0 0", we_q.size(), busy); end
   endtask

   task automatic test_illegal();
      mem[3] = 16'h0001; mem[4] = enc(2'b11, 3'd6, 3'd0, 8'h00); mem[5] = enc(2'b00, 3'd4, 3'd0, 8'h00);
      run_prog(6, 0);
      checks++; if (we_q.size() !== 5) begin fails++; $display("FAIL ill_we_count: got %0d required 5", we_q.size()); end
      checks++; if (illegal !== 1'b1) begin fails++; $display("FAIL ill_flag: got %0b required 1", illegal); end
      checks++; if (retired !== 16'd5) begin fails++; $display("FAIL ill_retired: got %0d required 5", retired); end
      checks++; if (fa_q.size() !== 6 || fa_q[5] !== 8'd5) begin fails++; $display("FAIL ill_next_fetch: got %0d required 5", (fa_q.size() > 5) ? fa_q[5] : 8'hXX); end
      checks++; if (imem_addr !== 8'd6) begin fails++; $display("FAIL ill_pc: got %0d required 6", imem_addr); end
      repeat (3) @(negedge clk);
      checks++; if (illegal !== 1'b1) begin fails++; $display("FAIL ill_sticky: got %0b required 1", illegal); end
   endtask

   task automatic test_halt_op();
      mem[6] = enc(2'b10, 3'd5, 3'd0, 8'h00); mem[7] = enc(2'b00, 3'd7, 3'd0, 8'h00);
`ifdef SEQ_HALT_EN
      run_prog(100, 0);
      checks++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_flag: got %0b required 1", halted); end
      checks++; if (we_q.size() !== 0) begin fails++; $display("FAIL halt_no_we: got %0d required 0", we_q.size()); end
      checks++; if (imem_addr !== 8'd6) begin fails++; $display("FAIL halt_pc: got %0d required 6", imem_addr); end
      run_prog(1, 0);
      checks++; if (fa_q.size() !== 1 || fa_q[0] !== 8'd7) begin fails++; $display("FAIL halt_resume_fetch: got %0d required 7", (fa_q.size() > 0) ? fa_q[0] : 8'hXX); end
`else
      run_prog(2, 0);
      checks++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_tied: got %0b required 0", halted); end
      checks++; if (fa_q.size() !== 2 || fa_q[1] !== 8'd7) begin fails++; $display("FAIL halt_as_ill_fetch: got %0d required 7", (fa_q.size() > 1) ? fa_q[1] : 8'hXX); end
      checks++; if (we_q.size() !== 1) begin fails++; $display("FAIL halt_as_ill_we: got %0d required 1", we_q.size()); end
`endif
      checks++; if (imem_addr !== 8'd8) begin fails++; $display("FAIL halt_end_pc: got %0d required 8", imem_addr); end
   endtask

   task automatic test_start_stop_together();
      mem[8] = 16'h0001;
      run_prog(0, 0);
      checks++; if (we_q.size() !== 1) begin fails++; $display("FAIL ss_we_count: got %0d required 1", we_q.size()); end
      checks++; if (illegal !== 1'b0) begin fails++; $display("FAIL ss_illegal_clear: got %0b required 0", illegal); end
      checks++; if (imem_addr !== 8'd9) begin fails++; $display("FAIL ss_pc: got %0d required 9", imem_addr); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0001;
      mem[0] = enc(2'b00, 3'd1, 3'd0, 8'd5);
      mem[1] = enc(2'b01, 3'd2, 3'd1, 8'd0);
      rst_n = 1'b0; start = 1'b0; stop = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_two_instr();
      test_wait_states();
      test_pc_wrap();
      test_reset_mid();
      test_illegal();
      test_halt_op();
      test_start_stop_together();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
